// File: rtl/johnson_count_decoder.sv
// johnson_count_decoder
//   Receive-side decoder for a WIDTH-bit Johnson code bus.
//   It validates each sampled code and decodes it to a binary index.
//   It also tracks the step direction and flags illegal codes and skipped states.
//   Optional feature macro: JOHNSON_DEC_ERR_CNT_EN enables an 8-bit saturating error
//   counter on err_count. When the macro is undefined, err_count is tied to zero.
module johnson_count_decoder #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 2,
  localparam int unsigned IW        = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] johnson_in,
  input  logic             clear_err,
  output logic [IW-1:0]    index_out,
  output logic             index_valid,
  output logic             step,
  output logic             dir_up,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic             err_sticky,
  output logic [7:0]       err_count
);

  localparam int unsigned N  = 2 * WIDTH;
  localparam int unsigned DW = IW + 1;
  localparam int unsigned CW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] index_d;
  logic          index_valid_d;
  logic          step_d;
  logic          dir_up_d;
  logic          code_err_d;
  logic          seq_err_d;
  logic          err_sticky_d;
  logic          any_err_d;

  logic          code_legal;
  logic [IW-1:0] code_idx;
  logic [DW-1:0] diff_w;
  logic [IW-1:0] delta;
  logic          is_hold;
  logic          is_up;
  logic          is_dn;

  // Index of a Johnson code. A code with bit 0 set is in the filling half, so the index
  // is its count of ones. Otherwise it is in the emptying half, so the index is N minus
  // its count of ones.
  function automatic logic [IW-1:0] decode_idx(input logic [WIDTH-1:0] code);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (code[i]) ones++;
    end
    if (ones == 0) return '0;
    if (code[0]) return IW'(ones);
    return IW'(N - ones);
  endfunction

  // A legal code has at most one transition between adjacent bits.
  function automatic logic is_legal(input logic [WIDTH-1:0] code);
    logic [WIDTH-2:0] t;
    t = code[WIDTH-1:1] ^ code[WIDTH-2:0];
    return (t & (t - (WIDTH-1)'(1))) == '0;
  endfunction

  // Classify the new sample against the previous legal index, using a modulo-N distance.
  always_comb begin
    code_legal = is_legal(johnson_in);
    code_idx   = decode_idx(johnson_in);
    diff_w     = {1'b0, code_idx} + DW'(N) - {1'b0, index_out};
    if (diff_w >= DW'(N)) diff_w = diff_w - DW'(N);
    delta      = diff_w[IW-1:0];
    is_hold    = (delta == '0);
    is_up      = (delta == IW'(1));
    is_dn      = (delta == IW'(N - 1));
  end

  // Next state and next register values for the lock tracker.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    index_d       = index_out;
    dir_up_d      = dir_up;
    index_valid_d = 1'b0;
    step_d        = 1'b0;
    code_err_d    = 1'b0;
    seq_err_d     = 1'b0;

    if (sample_en) begin
      if (!code_legal) begin
        code_err_d = 1'b1;
        cnt_d      = '0;
        state_d    = UNLOCKED;
      end else begin
        index_d       = code_idx;
        index_valid_d = 1'b1;
        unique case (state_q)
          UNLOCKED: begin
            if (cnt_q == '0) begin
              cnt_d = CW'(1);
            end else if (is_hold || is_up || is_dn) begin
              cnt_d = cnt_q + CW'(1);
              if (!is_hold) begin
                step_d   = 1'b1;
                dir_up_d = is_up;
              end
            end else begin
              seq_err_d = 1'b1;
              cnt_d     = CW'(1);
            end
            if (cnt_d >= CW'(LOCK_COUNT)) state_d = LOCKED;
          end
          LOCKED: begin
            if (is_up || is_dn) begin
              step_d   = 1'b1;
              dir_up_d = is_up;
            end else if (!is_hold) begin
              seq_err_d = 1'b1;
              cnt_d     = CW'(1);
              state_d   = UNLOCKED;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end

    any_err_d = code_err_d | seq_err_d;
    if (any_err_d)      err_sticky_d = 1'b1;
    else if (clear_err) err_sticky_d = 1'b0;
    else                err_sticky_d = err_sticky;
  end

  // State, lock counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNLOCKED;
      cnt_q       <= '0;
      index_out   <= '0;
      index_valid <= 1'b0;
      step        <= 1'b0;
      dir_up      <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      index_out   <= index_d;
      index_valid <= index_valid_d;
      step        <= step_d;
      dir_up      <= dir_up_d;
      code_err    <= code_err_d;
      seq_err     <= seq_err_d;
      locked      <= (state_d == LOCKED);
      err_sticky  <= err_sticky_d;
    end
  end

`ifdef JOHNSON_DEC_ERR_CNT_EN
  // Saturating error counter. A new error in the same cycle as clear_err restarts it at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (any_err_d) begin
      if (clear_err)                err_count <= 8'd1;
      else if (err_count != 8'hFF)  err_count <= err_count + 8'd1;
    end else if (clear_err) begin
      err_count <= 8'd0;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_johnson_count_decoder.sv
// Self-checking bench for johnson_count_decoder (WIDTH=4, LOCK_COUNT=2).
module tb_johnson_count_decoder;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned LOCK_COUNT = 2;
  localparam int unsigned N          = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic [3:0] johnson_in = 4'b0000;
  logic       clear_err = 1'b0;
  logic [2:0] index_out;
  logic       index_valid, step, dir_up, code_err, seq_err, locked, err_sticky;
  logic [7:0] err_count;

  johnson_count_decoder #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .johnson_in(johnson_in),
    .clear_err(clear_err), .index_out(index_out), .index_valid(index_valid),
    .step(step), .dir_up(dir_up), .code_err(code_err), .seq_err(seq_err),
    .locked(locked), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Observed vector: {index, valid, step, dir_up, code_err, seq_err, locked, sticky, count}
  logic [17:0] obs;
  assign obs = {index_out, index_valid, step, dir_up, code_err, seq_err, locked,
                err_sticky, err_count};

  logic [17:0] exp_q[$];
  logic [3:0]  codes   [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                               4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0]  illegal [8] = '{4'b0101, 4'b0110, 4'b1010, 4'b1001,
                               4'b0100, 4'b0010, 4'b1011, 4'b1101};

  int m_idx, m_cnt, m_errcnt;
  bit m_locked, m_dir, m_sticky;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_errcnt = 0;
    m_locked = 0; m_dir = 0; m_sticky = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sample_en = 1'b0; clear_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle, push the expected outputs, and return one time unit after the edge.
  task automatic send(input bit en, input logic [3:0] code, input bit clr);
    int k, d;
    bit vld, stp, ce, se;
    logic [7:0] cnt_field;
    @(negedge clk);
    sample_en = en; johnson_in = code; clear_err = clr;
    vld = 0; stp = 0; ce = 0; se = 0;
    if (en) begin
      k = -1;
      for (int i = 0; i < 8; i++) if (codes[i] == code) k = i;
      if (k < 0) begin
        ce = 1; m_cnt = 0; m_locked = 0;
      end else begin
        d = (k - m_idx + int'(N)) % int'(N);
        vld = 1;
        if (!m_locked) begin
          if (m_cnt == 0) m_cnt = 1;
          else if (d == 0 || d == 1 || d == 7) begin
            m_cnt++;
            if (d != 0) begin stp = 1; m_dir = (d == 1); end
          end else begin
            se = 1; m_cnt = 1;
          end
          if (m_cnt >= int'(LOCK_COUNT)) m_locked = 1;
        end else begin
          if (d == 1 || d == 7) begin stp = 1; m_dir = (d == 1); end
          else if (d != 0) begin se = 1; m_locked = 0; m_cnt = 1; end
        end
        m_idx = k;
      end
    end
    if (ce || se) begin
      m_sticky = 1;
      m_errcnt = clr ? 1 : ((m_errcnt < 255) ? m_errcnt + 1 : 255);
    end else if (clr) begin
      m_sticky = 0;
      m_errcnt = 0;
    end
`ifdef JOHNSON_DEC_ERR_CNT_EN
    cnt_field = 8'(m_errcnt);
`else
    cnt_field = 8'd0;
`endif
    exp_q.push_back({3'(m_idx), vld, stp, m_dir, ce, se, m_locked, m_sticky, cnt_field});
    @(posedge clk);
    #1;
    sample_en = 1'b0; clear_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    do_reset();
    n_checks++;
    if (obs !== 18'd0) begin n_fail++; $display("FAIL reset_init: got %h want 0", obs); end
    send(1, 4'b0000, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL reset_s0: got %h want %h", obs, e); end
    send(1, 4'b0001, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL reset_s1: got %h want %h", obs, e); end
    send(1, 4'b0101, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL reset_s2: got %h want %h", obs, e); end
    // Assert reset while the clock is low, away from any edge.
    @(negedge clk); #2; rst_n = 1'b0; #1;
    n_checks++;
    if (obs !== 18'd0) begin n_fail++; $display("FAIL reset_async: got %h want 0", obs); end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 18'd0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", obs); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    send(1, 4'b0011, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL reset_after: got %h want %h", obs, e); end
    n_checks++;
    if ({locked, step, index_out} !== {1'b0, 1'b0, 3'd2}) begin
      n_fail++; $display("FAIL reset_unlocked: got lk=%b st=%b idx=%0d want 0 0 2", locked, step, index_out);
    end
  endtask

  task automatic test_up_lock();
    logic [3:0] seq [4] = '{4'b1000, 4'b0000, 4'b0001, 4'b0011};
    logic [2:0] want_idx [4] = '{3'd7, 3'd0, 3'd1, 3'd2};
    logic want_lk [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic want_st [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [17:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1, seq[i], 0); e = exp_q.pop_front();
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL up_lock_sb[%0d]: got %h want %h", i, obs, e); end
      n_checks++;
      if ({index_out, locked, step, index_valid} !== {want_idx[i], want_lk[i], want_st[i], 1'b1} ||
          (want_st[i] && dir_up !== 1'b1)) begin
        n_fail++;
        $display("FAIL up_lock[%0d]: got idx=%0d lk=%b st=%b dir=%b want idx=%0d lk=%b st=%b dir=1",
                 i, index_out, locked, step, dir_up, want_idx[i], want_lk[i], want_st[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [17:0] e;
    do_reset();
    send(1, 4'b0001, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL down_s0: got %h want %h", obs, e); end
    send(1, 4'b0000, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL down_s1: got %h want %h", obs, e); end
    send(1, 4'b1000, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL down_s2: got %h want %h", obs, e); end
    n_checks++;
    if ({index_out, step, dir_up, code_err, seq_err, locked} !== {3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL down_wrap: got idx=%0d st=%b dir=%b ce=%b se=%b lk=%b want 7 1 0 0 0 1",
               index_out, step, dir_up, code_err, seq_err, locked);
    end
  endtask

  task automatic test_illegal();
    logic [17:0] e;
    do_reset();
    send(1, 4'b0001, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL illegal_s0: got %h want %h", obs, e); end
    send(1, 4'b0011, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL illegal_s1: got %h want %h", obs, e); end
    send(1, 4'b0101, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL illegal_s2: got %h want %h", obs, e); end
    n_checks++;
    if ({code_err, seq_err, locked, index_out, err_sticky, index_valid} !==
        {1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_code: got ce=%b se=%b lk=%b idx=%0d sticky=%b vld=%b want 1 0 0 2 1 0",
               code_err, seq_err, locked, index_out, err_sticky, index_valid);
    end
    send(0, 4'b0000, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL illegal_idle: got %h want %h", obs, e); end
    n_checks++;
    if ({code_err, err_sticky, index_out} !== {1'b0, 1'b1, 3'd2}) begin
      n_fail++; $display("FAIL illegal_pulse: got ce=%b sticky=%b idx=%0d want 0 1 2", code_err, err_sticky, index_out);
    end
  endtask

  task automatic test_skip();
    logic [17:0] e;
    do_reset();
    send(1, 4'b0000, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL skip_s0: got %h want %h", obs, e); end
    send(1, 4'b0001, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL skip_s1: got %h want %h", obs, e); end
    send(1, 4'b0111, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL skip_s2: got %h want %h", obs, e); end
    n_checks++;
    if ({seq_err, code_err, index_out, locked} !== {1'b1, 1'b0, 3'd3, 1'b0}) begin
      n_fail++; $display("FAIL skip_detect: got se=%b ce=%b idx=%0d lk=%b want 1 0 3 0", seq_err, code_err, index_out, locked);
    end
    send(1, 4'b1111, 0); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL skip_s3: got %h want %h", obs, e); end
    n_checks++;
    if ({locked, index_out, seq_err} !== {1'b1, 3'd4, 1'b0}) begin
      n_fail++; $display("FAIL skip_relock: got lk=%b idx=%0d se=%b want 1 4 0", locked, index_out, seq_err);
    end
  endtask

  task automatic test_sticky_count();
    logic [17:0] e;
    logic [7:0]  want;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(1, illegal[i], 0); e = exp_q.pop_front();
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL sticky_err[%0d]: got %h want %h", i, obs, e); end
    end
`ifdef JOHNSON_DEC_ERR_CNT_EN
    want = 8'd3;
`else
    want = 8'd0;
`endif
    n_checks++;
    if ({err_sticky, err_count} !== {1'b1, want}) begin
      n_fail++; $display("FAIL sticky_three: got sticky=%b cnt=%0d want 1 %0d", err_sticky, err_count, want);
    end
    send(1, illegal[3], 1); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL sticky_clr_sb: got %h want %h", obs, e); end
`ifdef JOHNSON_DEC_ERR_CNT_EN
    want = 8'd1;
`else
    want = 8'd0;
`endif
    n_checks++;
    if ({err_sticky, err_count} !== {1'b1, want}) begin
      n_fail++; $display("FAIL sticky_clr_err: got sticky=%b cnt=%0d want 1 %0d", err_sticky, err_count, want);
    end
    send(0, 4'b0000, 1); e = exp_q.pop_front();
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL sticky_clear: got %h want %h", obs, e); end
    n_checks++;
    if ({err_sticky, err_count} !== 9'd0) begin
      n_fail++; $display("FAIL sticky_cleared: got sticky=%b cnt=%0d want 0 0", err_sticky, err_count);
    end
    for (int i = 0; i < 260; i++) begin
      send(1, illegal[i % 8], 0); e = exp_q.pop_front();
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL sat[%0d]: got %h want %h", i, obs, e); end
    end
`ifdef JOHNSON_DEC_ERR_CNT_EN
    want = 8'd255;
`else
    want = 8'd0;
`endif
    n_checks++;
    if (err_count !== want) begin
      n_fail++; $display("FAIL sat_value: got cnt=%0d want %0d", err_count, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    int k, r;
    bit en, clr;
    logic [3:0] code;
    do_reset();
    k = 0;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 19) == 0);
      r   = int'($urandom_range(0, 99));
      if (r < 65)      k = (k + 1) % 8;
      else if (r < 80) k = (k + 7) % 8;
      else if (r < 90) k = k;
      else if (r < 95) k = int'($urandom_range(0, 7));
      if (r >= 95) code = illegal[$urandom_range(0, 7)];
      else         code = codes[k];
      send(en, code, clr); e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b[%0d]: code=%b en=%b got %h want %h", i, code, en, obs, e); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_up_lock();
    test_down_wrap();
    test_illegal();
    test_skip();
    test_sticky_count();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
